// File: rtl/dm_dump_pkg.sv
// Shared types and defaults for the DM result dumper.
// Holds the FSM state encoding, the default mailbox/result-region constants
// (also used by the bench) and a helper that clamps the requested dump length.
package dm_dump_pkg;

    localparam int          DEF_ADDR_W       = 14;
    localparam int          DEF_DATA_W       = 32;
    localparam int          DEF_DUMP_MAX     = 64;
    localparam int          IDX_W            = 7;
    localparam logic [13:0] DEF_SIM_END_ADDR = 14'h3fff;
    localparam logic [31:0] DEF_END_CODE     = 32'hffff_ffff;
    localparam logic [13:0] DEF_TEST_START   = 14'h2000;

    typedef enum logic [2:0] {IDLE, WAIT_GNT, READ, DRAIN, DONE} dump_state_e;

    // Requested length limited to the maximum dump size.
    function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] len,
                                                   input int              max_len);
        return (int'(len) > max_len) ? IDX_W'(max_len) : len;
    endfunction

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry FIFO holding dump beats between the DM read port and the output.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data write one entry (caller never pushes when full without popping)
//   pop             remove head entry (caller only pops when not empty)
//   head            current head entry, all-zero after reset
//   empty, count    occupancy status, count in 0..2
module dump_fifo2 #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == 2'd0);

endmodule

// File: rtl/dm_result_dumper.sv
// DM result dumper.
// Snoops CPU writes to data memory; a full-word write of END_CODE to
// SIM_END_ADDR starts a dump. The block then requests the DM port, reads
// DM[TEST_START .. TEST_START+len-1] and streams the words on a valid/ready port.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   snoop_cs/web/a/di                CPU-side DM write snoop (web active-low)
//   dump_len                         words to dump, sampled on trigger, clamped to DUMP_MAX
//   clear                            DONE -> IDLE re-arm
//   dm_req / dm_gnt                  DM port ownership handshake
//   dm_cs, dm_oe, dm_a, dm_do        DM read port (data returns one cycle after issue)
//   out_valid/ready/data/idx/last    dump beat stream
//   busy, done                       status
//   dbg_state                        current FSM state
//
// Output handshake: a beat transfers in a cycle where out_valid and out_ready
// are both high. Once out_valid is raised it stays high and out_data, out_idx
// and out_last stay unchanged until that transfer happens.
module dm_result_dumper
    import dm_dump_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                DATA_W       = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] SIM_END_ADDR = DEF_SIM_END_ADDR,
    parameter logic [DATA_W-1:0] END_CODE     = DEF_END_CODE,
    parameter logic [ADDR_W-1:0] TEST_START   = DEF_TEST_START,
    parameter int                DUMP_MAX     = DEF_DUMP_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snoop_cs,
    input  logic [3:0]        snoop_web,
    input  logic [ADDR_W-1:0] snoop_a,
    input  logic [DATA_W-1:0] snoop_di,
    input  logic [IDX_W-1:0]  dump_len,
    input  logic              clear,
    output logic              dm_req,
    input  logic              dm_gnt,
    output logic              dm_cs,
    output logic              dm_oe,
    output logic [ADDR_W-1:0] dm_a,
    input  logic [DATA_W-1:0] dm_do,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output dump_state_e       dbg_state
);

    localparam int FW = DATA_W + IDX_W + 1;

    dump_state_e      state, state_nxt;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] rd_cnt;
    logic             inflight;
    logic [IDX_W-1:0] inflight_idx;
    logic             inflight_last;
    logic             trigger;
    logic [IDX_W-1:0] trig_len;
    logic             issue;
    logic             pop;
    logic             fifo_empty;
    logic [1:0]       fifo_count;
    logic [1:0]       occ;
    logic [FW-1:0]    fifo_head;

    assign trigger  = snoop_cs && (snoop_web == 4'b0000) &&
                      (snoop_a == SIM_END_ADDR) && (snoop_di == END_CODE);
    assign trig_len = clamp_len(dump_len, DUMP_MAX);

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid && out_ready;
    // Occupancy after this cycle's pop; counting the departing beat as free
    // space keeps issue running back-to-back at one word per cycle.
    assign occ       = fifo_count - {1'b0, pop};

    always_comb begin
        state_nxt = state;
        dm_req    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = (trig_len == '0) ? DONE : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                dm_req = 1'b1;
                if (dm_gnt) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                dm_req = 1'b1;
                issue  = dm_gnt && (({1'b0, occ} + {2'b00, inflight}) < 3'd2);
                if (issue && (rd_cnt == len_q - 1'b1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (clear) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            len_q         <= '0;
            rd_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_idx  <= '0;
            inflight_last <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (state == IDLE && trigger) begin
                len_q  <= trig_len;
                rd_cnt <= '0;
            end
            if (issue) begin
                rd_cnt        <= rd_cnt + 1'b1;
                inflight_idx  <= rd_cnt;
                inflight_last <= (rd_cnt == len_q - 1'b1);
            end
        end
    end

    assign dm_cs = issue;
    assign dm_oe = issue;
    assign dm_a  = issue ? (TEST_START + ADDR_W'(rd_cnt)) : '0;

    // Read data is tagged with its beat index and last flag as it enters the FIFO.
    dump_fifo2 #(.W(FW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({dm_do, inflight_idx, inflight_last}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_data  = fifo_head[FW-1 -: DATA_W];
    assign out_idx   = fifo_head[IDX_W:1];
    assign out_last  = fifo_head[0];

    assign busy      = (state == WAIT_GNT) || (state == READ) || (state == DRAIN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dm_result_dumper.sv
module tb_dm_result_dumper;
  import dm_dump_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          snoop_cs  = 1'b0;
  logic [3:0]    snoop_web = 4'hf;
  logic [AW-1:0] snoop_a   = '0;
  logic [DW-1:0] snoop_di  = '0;
  logic [6:0]    dump_len  = '0;
  logic          clear     = 1'b0;
  logic          dm_req;
  logic          dm_gnt    = 1'b1;
  logic          dm_cs;
  logic          dm_oe;
  logic [AW-1:0] dm_a;
  logic [DW-1:0] dm_do     = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [6:0]    out_idx;
  logic          out_last;
  logic          busy;
  logic          done;
  dump_state_e   dbg_state;

  dm_result_dumper dut (
    .clk       (clk),
    .rst       (rst),
    .snoop_cs  (snoop_cs),
    .snoop_web (snoop_web),
    .snoop_a   (snoop_a),
    .snoop_di  (snoop_di),
    .dump_len  (dump_len),
    .clear     (clear),
    .dm_req    (dm_req),
    .dm_gnt    (dm_gnt),
    .dm_cs     (dm_cs),
    .dm_oe     (dm_oe),
    .dm_a      (dm_a),
    .dm_do     (dm_do),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // DM model: synchronous read, data valid the cycle after the access.
  logic [DW-1:0] dm_mem [0:(1<<AW)-1];
  always @(posedge clk) if (dm_cs && dm_oe) dm_do <= dm_mem[dm_a];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  logic [DW-1:0] exp_q[$];
  int  exp_idx, cur_len;
  int  issued, accepted, viol_cs_nogt, viol_outst;
  int  first_issue_cyc, first_beat_cyc, last_beat_cyc, done_cyc;
  bit  done_seen, req_seen, valid_seen, prev_stall;
  logic [DW-1:0] held_data;
  logic [6:0]    held_idx;
  logic          held_last;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (dm_req) req_seen = 1'b1;
      if (out_valid) valid_seen = 1'b1;
      if (done && !done_seen) begin done_seen = 1'b1; done_cyc = cyc; end
      if (dm_cs && !dm_gnt) viol_cs_nogt++;
      if (dm_cs) begin
        if (issued == 0) first_issue_cyc = cyc;
        issued++;
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_data);
        check("hold_idx", out_idx, held_idx);
        check("hold_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL beat_unexpected: got data %0h idx %0d, expected no beat", out_data, out_idx);
        end else begin
          logic [DW-1:0] ed;
          ed = exp_q.pop_front();
          check("beat_data", out_data, ed);
          check("beat_idx", out_idx, exp_idx);
          check("beat_last", out_last, (exp_idx == cur_len - 1) ? 1 : 0);
        end
        if (accepted == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        accepted++;
        exp_idx++;
      end
      if (issued - accepted > 2) viol_outst++;
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      held_idx   = out_idx;
      held_last  = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    issued = 0; accepted = 0; viol_cs_nogt = 0; viol_outst = 0;
    done_seen = 0; req_seen = 0; valid_seen = 0; prev_stall = 0;
    exp_idx = 0; exp_q.delete();
    first_issue_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
  endtask

  task automatic snoop_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] web, input logic [6:0] len, output int tcyc);
    snoop_cs = 1'b1; snoop_a = a; snoop_di = d; snoop_web = web; dump_len = len;
    tcyc = cyc;
    tick();
    snoop_cs = 1'b0; snoop_web = 4'hf; snoop_di = '0;
  endtask

  task automatic load_region(input logic [DW-1:0] base);
    for (int i = 0; i < 128; i++) dm_mem[DEF_TEST_START + 14'(i)] = base + DW'(i);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dm_req"}, dm_req, 0);
    check({tag, "_dm_cs"}, dm_cs, 0);
    check({tag, "_dm_oe"}, dm_oe, 0);
    check({tag, "_dm_a"}, dm_a, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  typedef struct {
    logic [6:0]    len;
    bit            ready_toggle;
    bit            gnt_drop;
    int            exp_beats;
    logic [DW-1:0] base;
    bit            full_rate;
  } row_t;

  task automatic run_row(input row_t r, input string name);
    int tcyc;
    int drop_left;
    bit drop_done;
    clear_mon();
    load_region(r.base);
    cur_len = r.exp_beats;
    for (int i = 0; i < r.exp_beats; i++) exp_q.push_back(r.base + DW'(i));
    out_ready = 1'b1; dm_gnt = 1'b1;
    drop_left = 0; drop_done = 0;
    snoop_write(DEF_SIM_END_ADDR, DEF_END_CODE, 4'b0000, r.len, tcyc);
    for (int c = 0; c < 600 && !done_seen; c++) begin
      if (r.ready_toggle) out_ready = ~out_ready;
      if (r.gnt_drop && !drop_done && issued >= 2) begin drop_done = 1; drop_left = 5; end
      if (drop_left > 0) begin dm_gnt = 1'b0; drop_left--; clear = 1'b1; end
      else begin dm_gnt = 1'b1; clear = 1'b0; end
      tick();
    end
    clear = 1'b0; out_ready = 1'b1; dm_gnt = 1'b1;
    check({name, "_done_reached"}, done_seen, 1);
    check({name, "_beats"}, accepted, r.exp_beats);
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_cs_without_gnt"}, viol_cs_nogt, 0);
    check({name, "_outstanding"}, viol_outst, 0);
    if (r.exp_beats == 0) begin
      check({name, "_done_cycle"}, done_cyc, tcyc + 1);
      check({name, "_no_req"}, req_seen, 0);
      check({name, "_no_valid"}, valid_seen, 0);
    end else begin
      check({name, "_done_after_last"}, done_cyc, last_beat_cyc + 1);
    end
    if (r.full_rate) begin
      check({name, "_first_issue"}, first_issue_cyc, tcyc + 2);
      check({name, "_first_beat"}, first_beat_cyc, first_issue_cyc + 2);
      check({name, "_back_to_back"}, last_beat_cyc - first_beat_cyc, r.exp_beats - 1);
    end
    tick(); tick();
    check({name, "_done_holds"}, done, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check({name, "_cleared_done"}, done, 0);
    check({name, "_cleared_state"}, dbg_state, IDLE);
  endtask

  // ---------------- test ----------------
  row_t rows[7];
  int tcyc_n;

  initial begin
    rows[0] = '{len: 7'd4,   ready_toggle: 0, gnt_drop: 0, exp_beats: 4,  base: 32'h0000_0001, full_rate: 1};
    rows[1] = '{len: 7'd3,   ready_toggle: 1, gnt_drop: 0, exp_beats: 3,  base: 32'hA500_0010, full_rate: 0};
    rows[2] = '{len: 7'd8,   ready_toggle: 0, gnt_drop: 1, exp_beats: 8,  base: 32'h1234_0100, full_rate: 0};
    rows[3] = '{len: 7'd0,   ready_toggle: 0, gnt_drop: 0, exp_beats: 0,  base: 32'h5555_0000, full_rate: 0};
    rows[4] = '{len: 7'd100, ready_toggle: 0, gnt_drop: 0, exp_beats: 64, base: 32'hC0DE_0000, full_rate: 1};
    rows[5] = '{len: 7'd64,  ready_toggle: 0, gnt_drop: 0, exp_beats: 64, base: 32'h0BAD_F000, full_rate: 1};
    rows[6] = '{len: 7'd1,   ready_toggle: 0, gnt_drop: 0, exp_beats: 1,  base: 32'h7FFF_FFFE, full_rate: 1};

    for (int a = 0; a < (1 << AW); a++) dm_mem[a] = 32'hDEAD_0000 | DW'(a);
    clear_mon();
    cur_len = 0;

    tick(); tick();
    check_reset_vals("reset");
    check("reset_state", dbg_state, IDLE);
    rst = 1'b1;
    tick();

    // Non-triggering writes: wrong data, partial bytes, wrong address, no chip select.
    clear_mon();
    snoop_write(DEF_SIM_END_ADDR, 32'hffff_fffe, 4'b0000, 7'd4, tcyc_n);
    snoop_write(DEF_SIM_END_ADDR, DEF_END_CODE, 4'b1110, 7'd4, tcyc_n);
    snoop_write(DEF_SIM_END_ADDR - 14'd1, DEF_END_CODE, 4'b0000, 7'd4, tcyc_n);
    snoop_cs = 1'b0; snoop_a = DEF_SIM_END_ADDR; snoop_di = DEF_END_CODE; snoop_web = 4'b0000;
    tick();
    snoop_web = 4'hf; snoop_di = '0;
    tick(); tick(); tick();
    check("notrig_req", req_seen, 0);
    check("notrig_busy", busy, 0);
    check("notrig_done", done, 0);

    for (int i = 0; i < 7; i++) run_row(rows[i], $sformatf("row%0d", i));

    // Reset in the middle of a dump, then a clean re-trigger.
    clear_mon();
    load_region(32'h7700_0000);
    cur_len = 16;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h7700_0000 + DW'(i));
    snoop_write(DEF_SIM_END_ADDR, DEF_END_CODE, 4'b0000, 7'd16, tcyc_n);
    for (int c = 0; c < 50 && accepted < 2; c++) tick();
    check("rst_mid_two_beats", accepted, 2);
    check("rst_mid_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1 check_reset_vals("rst_mid");
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_mid_state", dbg_state, IDLE);
    run_row('{len: 7'd5, ready_toggle: 0, gnt_drop: 0, exp_beats: 5, base: 32'h3300_0000, full_rate: 1},
            "retrig");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
